intr_prio_ctrl: RTL and testbench

INTR_PRIO_CTRL -- requirements
Module: intr_prio_ctrl

---
 rtl/intr_prio_ctrl.sv | 134 +++++++++++++
 tb/tb_intr_prio_ctrl.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/intr_prio_ctrl.sv
// Prioritised interrupt controller: per-bit pending capture, mask and group gating,
// fixed-priority winner selection and a valid/ready presentation FSM with a one-cycle gap.
module intr_prio_ctrl #(
  parameter  int NUM_CH    = 9,
  parameter  int NUM_GRP   = 3,
  parameter  int EDGE_MODE = 1,
  localparam int CH_W      = (NUM_CH  > 1) ? $clog2(NUM_CH)  : 1,
  localparam int GRP_W     = (NUM_GRP > 1) ? $clog2(NUM_GRP) : 1,
  localparam int N         = NUM_GRP * NUM_CH
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N-1:0]       req_i,
  input  logic [NUM_GRP-1:0] grp_en,
  input  logic               mask_wr,
  input  logic [N-1:0]       mask_data,
  output logic               irq_valid,
  input  logic               irq_ready,
  output logic [GRP_W-1:0]   irq_grp,
  output logic [CH_W-1:0]    irq_ch,
  output logic [NUM_GRP-1:0] grp_any,
  output logic [N-1:0]       pend_o
);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_PRESENT = 2'd1;
  localparam logic [1:0] S_GAP     = 2'd2;

  logic [N-1:0]       r_req_q;
  logic [N-1:0]       r_pend;
  logic [N-1:0]       r_mask;
  logic [1:0]         r_state;
  logic [GRP_W-1:0]   r_irq_grp;
  logic [CH_W-1:0]    r_irq_ch;
  logic [NUM_GRP-1:0] r_grp_any;

  logic [N-1:0]       w_set;
  logic [N-1:0]       w_elig;
  logic [N-1:0]       w_ack_clr;
  logic [NUM_GRP-1:0] w_grp_or;
  logic [NUM_GRP-1:0] w_grp_oh;
  logic [NUM_CH-1:0]  w_sel_ch;
  logic [NUM_CH-1:0]  w_ch_oh;
  logic [GRP_W-1:0]   w_win_grp;
  logic [CH_W-1:0]    w_win_ch;
  logic               w_accept;

  // OR-reduction chains used as priority encoders over the one-hot winners
  logic [GRP_W-1:0]   w_genc [NUM_GRP+1];
  logic [NUM_CH-1:0]  w_selc [NUM_GRP+1];
  logic [CH_W-1:0]    w_cenc [NUM_CH+1];

  if (EDGE_MODE != 0) begin : g_edge
    assign w_set = req_i & ~r_req_q;
  end else begin : g_level
    assign w_set = req_i;
  end

  assign w_accept = (r_state == S_PRESENT) && irq_ready;

  assign w_genc[0] = '0;
  assign w_selc[0] = '0;
  for (genvar g = 0; g < NUM_GRP; g++) begin : g_grp
    assign w_elig[g*NUM_CH +: NUM_CH] = r_pend[g*NUM_CH +: NUM_CH] & ~r_mask[g*NUM_CH +: NUM_CH]
                                        & {NUM_CH{grp_en[g]}};
    assign w_grp_or[g] = |w_elig[g*NUM_CH +: NUM_CH];
    assign w_genc[g+1] = w_genc[g] | ({GRP_W{w_grp_oh[g]}} & GRP_W'(g));
    assign w_selc[g+1] = w_selc[g] | ({NUM_CH{w_grp_oh[g]}} & w_elig[g*NUM_CH +: NUM_CH]);
    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
      assign w_ack_clr[g*NUM_CH + c] = w_accept && (r_irq_grp == GRP_W'(g)) && (r_irq_ch == CH_W'(c));
    end
  end

  // Lowest set bit wins at both levels: group first, then channel within that group
  assign w_grp_oh  = w_grp_or & (~w_grp_or + NUM_GRP'(1));
  assign w_win_grp = w_genc[NUM_GRP];
  assign w_sel_ch  = w_selc[NUM_GRP];
  assign w_ch_oh   = w_sel_ch & (~w_sel_ch + NUM_CH'(1));

  assign w_cenc[0] = '0;
  for (genvar c = 0; c < NUM_CH; c++) begin : g_cenc
    assign w_cenc[c+1] = w_cenc[c] | ({CH_W{w_ch_oh[c]}} & CH_W'(c));
  end
  assign w_win_ch = w_cenc[NUM_CH];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_req_q   <= '0;
      r_pend    <= '0;
      r_mask    <= '1;
      r_grp_any <= '0;
    end else begin
      r_req_q   <= req_i;
      // A new set condition overrides the acknowledge clear of the same bit
      r_pend    <= w_set | (r_pend & ~w_ack_clr);
      r_grp_any <= w_grp_or;
      if (mask_wr) begin
        r_mask <= mask_data;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_irq_grp <= '0;
      r_irq_ch  <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (|w_elig) begin
            r_state   <= S_PRESENT;
            r_irq_grp <= w_win_grp;
            r_irq_ch  <= w_win_ch;
          end
        end
        S_PRESENT: begin
          if (irq_ready) begin
            r_state <= S_GAP;
          end
        end
        S_GAP:   r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign irq_valid = (r_state == S_PRESENT);
  assign irq_grp   = r_irq_grp;
  assign irq_ch    = r_irq_ch;
  assign grp_any   = r_grp_any;
  assign pend_o    = r_pend;

endmodule

// File: tb/tb_intr_prio_ctrl.sv
// Bench for intr_prio_ctrl: directed vector table, random traffic against a behavioural
// model, and a short scenario on a reduced 2-group x 4-channel build.
module tb_intr_prio_ctrl;

  localparam int NCH  = 9;
  localparam int NGRP = 3;
  localparam int N    = NCH * NGRP;

  logic         clk;
  logic         rst;
  logic [N-1:0] req_i;
  logic [2:0]   grp_en;
  logic         mask_wr;
  logic [N-1:0] mask_data;
  logic         irq_ready;
  logic         irq_valid;
  logic [1:0]   irq_grp;
  logic [3:0]   irq_ch;
  logic [2:0]   grp_any;
  logic [N-1:0] pend_o;

  logic       s_rst;
  logic [7:0] s_req;
  logic [1:0] s_en;
  logic       s_mwr;
  logic [7:0] s_mdata;
  logic       s_ready;
  logic       s_valid;
  logic [0:0] s_grp;
  logic [1:0] s_ch;
  logic [1:0] s_any;
  logic [7:0] s_pend;

  int checks = 0;
  int errors = 0;

  intr_prio_ctrl u_dut (
    .clk(clk), .rst(rst), .req_i(req_i), .grp_en(grp_en), .mask_wr(mask_wr),
    .mask_data(mask_data), .irq_valid(irq_valid), .irq_ready(irq_ready),
    .irq_grp(irq_grp), .irq_ch(irq_ch), .grp_any(grp_any), .pend_o(pend_o)
  );

  intr_prio_ctrl #(.NUM_CH(4), .NUM_GRP(2), .EDGE_MODE(1)) u_small (
    .clk(clk), .rst(s_rst), .req_i(s_req), .grp_en(s_en), .mask_wr(s_mwr),
    .mask_data(s_mdata), .irq_valid(s_valid), .irq_ready(s_ready),
    .irq_grp(s_grp), .irq_ch(s_ch), .grp_any(s_any), .pend_o(s_pend)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  typedef struct {
    logic         r;
    logic [N-1:0] rq;
    logic [2:0]   en;
    logic         mw;
    logic [N-1:0] md;
    logic         rd;
    logic         ev;
    logic [1:0]   eg;
    logic [3:0]   ec;
    logic [N-1:0] ep;
    logic [2:0]   ea;
  } vec_t;

  vec_t tbl[$];

  // Behavioural model: pending set, in-flight vector and a cool-down after each acceptance
  logic [N-1:0] m_pend, m_reqq, m_mask;
  logic         m_valid;
  int           m_cool, m_grp, m_ch;
  logic [2:0]   m_any;

  function automatic logic [N-1:0] b(input int i);
    b = N'(1) << i;
  endfunction

  function automatic vec_t mk(input logic r, input logic [N-1:0] rq, input logic [2:0] en,
                              input logic mw, input logic [N-1:0] md, input logic rd,
                              input logic ev, input int eg, input int ec,
                              input logic [N-1:0] ep, input logic [2:0] ea);
    vec_t v;
    v.r = r; v.rq = rq; v.en = en; v.mw = mw; v.md = md; v.rd = rd;
    v.ev = ev; v.eg = 2'(eg); v.ec = 4'(ec); v.ep = ep; v.ea = ea;
    return v;
  endfunction

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic model_edge();
    logic [N-1:0] set_v, clr;
    logic [2:0]   any_n;
    int           win;
    if (rst) begin
      m_pend = '0; m_reqq = '0; m_mask = '1; m_valid = 1'b0;
      m_cool = 0; m_grp = 0; m_ch = 0; m_any = '0;
      return;
    end
    set_v = req_i & ~m_reqq;
    win   = -1;
    any_n = '0;
    for (int i = 0; i < N; i++) begin
      if (m_pend[i] && !m_mask[i] && grp_en[i / NCH]) begin
        if (win < 0) win = i;
        any_n[i / NCH] = 1'b1;
      end
    end
    clr = '0;
    if (m_valid) begin
      if (irq_ready) begin
        clr[m_grp * NCH + m_ch] = 1'b1;
        m_valid = 1'b0;
        m_cool  = 1;
      end
    end else if (m_cool > 0) begin
      m_cool--;
    end else if (win >= 0) begin
      m_valid = 1'b1;
      m_grp   = win / NCH;
      m_ch    = win % NCH;
    end
    m_pend = set_v | (m_pend & ~clr);
    if (mask_wr) m_mask = mask_data;
    m_reqq = req_i;
    m_any  = any_n;
  endtask

  task automatic tick();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; req_i = '0; grp_en = 3'b111; mask_wr = 1'b0; mask_data = '0; irq_ready = 1'b0;
    s_rst = 1'b1; s_req = '0; s_en = 2'b11; s_mwr = 1'b0; s_mdata = '0; s_ready = 1'b0;

    //             r  rq          en     mw md    rd  ev g  c  ep          ea
    tbl.push_back(mk(1, '0,        3'b111, 0, '0,   0,  0, 0, 0, '0,        3'b000));
    tbl.push_back(mk(0, '0,        3'b111, 1, '0,   0,  0, 0, 0, '0,        3'b000));
    tbl.push_back(mk(0, b(13),     3'b111, 0, '0,   0,  0, 0, 0, b(13),     3'b000));
    tbl.push_back(mk(0, '0,        3'b111, 0, '0,   0,  1, 1, 4, b(13),     3'b010));
    tbl.push_back(mk(0, '0,        3'b111, 0, '0,   1,  0, 0, 0, '0,        3'b010));
    tbl.push_back(mk(0, '0,        3'b111, 0, '0,   0,  0, 0, 0, '0,        3'b000));
    tbl.push_back(mk(0, b(20)|b(5),3'b111, 0, '0,   0,  0, 0, 0, b(20)|b(5),3'b000));
    tbl.push_back(mk(0, '0,        3'b111, 0, '0,   0,  1, 0, 5, b(20)|b(5),3'b101));
    tbl.push_back(mk(0, '0,        3'b111, 0, '0,   1,  0, 0, 0, b(20),     3'b101));
    tbl.push_back(mk(0, '0,        3'b111, 0, '0,   0,  0, 0, 0, b(20),     3'b100));
    tbl.push_back(mk(0, '0,        3'b111, 0, '0,   0,  1, 2, 2, b(20),     3'b100));
    tbl.push_back(mk(0, '0,        3'b111, 0, '0,   1,  0, 0, 0, '0,        3'b100));
    tbl.push_back(mk(0, '0,        3'b111, 0, '0,   0,  0, 0, 0, '0,        3'b000));
    tbl.push_back(mk(0, b(5),      3'b111, 1, b(5), 0,  0, 0, 0, b(5),      3'b000));
    tbl.push_back(mk(0, '0,        3'b111, 0, '0,   0,  0, 0, 0, b(5),      3'b000));
    tbl.push_back(mk(0, '0,        3'b111, 0, '0,   0,  0, 0, 0, b(5),      3'b000));
    tbl.push_back(mk(0, '0,        3'b111, 1, '0,   0,  0, 0, 0, b(5),      3'b000));
    tbl.push_back(mk(0, '0,        3'b111, 0, '0,   0,  1, 0, 5, b(5),      3'b001));
    tbl.push_back(mk(0, '0,        3'b111, 0, '0,   1,  0, 0, 0, '0,        3'b001));
    tbl.push_back(mk(0, '0,        3'b111, 0, '0,   0,  0, 0, 0, '0,        3'b000));
    tbl.push_back(mk(0, b(9),      3'b111, 0, '0,   0,  0, 0, 0, b(9),      3'b000));
    tbl.push_back(mk(0, '0,        3'b111, 0, '0,   0,  1, 1, 0, b(9),      3'b010));
    tbl.push_back(mk(0, b(0),      3'b101, 0, '0,   0,  1, 1, 0, b(9)|b(0), 3'b000));
    tbl.push_back(mk(0, '0,        3'b101, 0, '0,   0,  1, 1, 0, b(9)|b(0), 3'b001));
    tbl.push_back(mk(0, '0,        3'b111, 0, '0,   1,  0, 0, 0, b(0),      3'b011));
    tbl.push_back(mk(0, '0,        3'b111, 0, '0,   0,  0, 0, 0, b(0),      3'b001));
    tbl.push_back(mk(0, '0,        3'b111, 0, '0,   0,  1, 0, 0, b(0),      3'b001));
    tbl.push_back(mk(0, '0,        3'b111, 0, '0,   1,  0, 0, 0, '0,        3'b001));
    tbl.push_back(mk(0, '0,        3'b111, 0, '0,   1,  0, 0, 0, '0,        3'b000));
    tbl.push_back(mk(0, '0,        3'b111, 0, '0,   1,  0, 0, 0, '0,        3'b000));
    tbl.push_back(mk(0, b(3),      3'b111, 0, '0,   0,  0, 0, 0, b(3),      3'b000));
    tbl.push_back(mk(0, '0,        3'b111, 0, '0,   0,  1, 0, 3, b(3),      3'b001));
    tbl.push_back(mk(0, b(3),      3'b111, 0, '0,   1,  0, 0, 0, b(3),      3'b001));
    tbl.push_back(mk(0, '0,        3'b111, 0, '0,   0,  0, 0, 0, b(3),      3'b001));
    tbl.push_back(mk(0, '0,        3'b111, 0, '0,   0,  1, 0, 3, b(3),      3'b001));
    tbl.push_back(mk(0, '0,        3'b111, 0, '0,   1,  0, 0, 0, '0,        3'b001));
    tbl.push_back(mk(0, '0,        3'b111, 0, '0,   0,  0, 0, 0, '0,        3'b000));
    tbl.push_back(mk(0, b(13),     3'b111, 0, '0,   0,  0, 0, 0, b(13),     3'b000));
    tbl.push_back(mk(0, '0,        3'b111, 0, '0,   0,  1, 1, 4, b(13),     3'b010));
    tbl.push_back(mk(1, b(22),     3'b111, 0, '0,   0,  0, 0, 0, '0,        3'b000));
    tbl.push_back(mk(0, b(22),     3'b111, 0, '0,   0,  0, 0, 0, b(22),     3'b000));
    tbl.push_back(mk(0, b(22),     3'b111, 0, '0,   0,  0, 0, 0, b(22),     3'b000));
    tbl.push_back(mk(0, b(22),     3'b111, 1, '0,   0,  0, 0, 0, b(22),     3'b000));
    tbl.push_back(mk(0, b(22),     3'b111, 0, '0,   0,  1, 2, 4, b(22),     3'b100));
    tbl.push_back(mk(0, '0,        3'b111, 0, '0,   1,  0, 0, 0, '0,        3'b100));
    tbl.push_back(mk(0, '0,        3'b111, 0, '0,   0,  0, 0, 0, '0,        3'b000));

    foreach (tbl[i]) begin
      rst = tbl[i].r; req_i = tbl[i].rq; grp_en = tbl[i].en;
      mask_wr = tbl[i].mw; mask_data = tbl[i].md; irq_ready = tbl[i].rd;
      tick();
      check($sformatf("vec%0d valid", i), 64'(irq_valid), 64'(tbl[i].ev));
      check($sformatf("vec%0d pend", i), 64'(pend_o), 64'(tbl[i].ep));
      check($sformatf("vec%0d grp_any", i), 64'(grp_any), 64'(tbl[i].ea));
      if (tbl[i].ev || tbl[i].r) begin
        check($sformatf("vec%0d grp", i), 64'(irq_grp), 64'(tbl[i].eg));
        check($sformatf("vec%0d ch", i), 64'(irq_ch), 64'(tbl[i].ec));
      end
    end

    for (int cyc = 0; cyc < 3000; cyc++) begin
      rst = ($urandom_range(299) == 0);
      for (int i = 0; i < N; i++) req_i[i] = ($urandom_range(7) == 0);
      if ($urandom_range(15) == 0) grp_en = 3'($urandom_range(7));
      mask_wr = ($urandom_range(19) == 0);
      for (int i = 0; i < N; i++) mask_data[i] = ($urandom_range(3) == 0);
      irq_ready = $urandom_range(1) == 1;
      tick();
      check($sformatf("rnd%0d valid", cyc), 64'(irq_valid), 64'(m_valid));
      check($sformatf("rnd%0d pend", cyc), 64'(pend_o), 64'(m_pend));
      check($sformatf("rnd%0d grp_any", cyc), 64'(grp_any), 64'(m_any));
      if (m_valid) begin
        check($sformatf("rnd%0d grp", cyc), 64'(irq_grp), 64'(m_grp));
        check($sformatf("rnd%0d ch", cyc), 64'(irq_ch), 64'(m_ch));
      end
    end

    rst = 1'b1; req_i = '0; mask_wr = 1'b0; irq_ready = 1'b0;
    tick();
    check("small reset valid", 64'(s_valid), 64'(0));
    check("small reset pend", 64'(s_pend), 64'(0));
    s_rst = 1'b0; s_mwr = 1'b1; s_mdata = '0;
    tick();
    s_mwr = 1'b0; s_req = 8'h40;
    tick();
    check("small pend set", 64'(s_pend), 64'(8'h40));
    check("small valid early", 64'(s_valid), 64'(0));
    s_req = '0;
    tick();
    check("small valid", 64'(s_valid), 64'(1));
    check("small grp", 64'(s_grp), 64'(1));
    check("small ch", 64'(s_ch), 64'(2));
    check("small grp_any", 64'(s_any), 64'(2'b10));
    s_ready = 1'b1;
    tick();
    check("small accept valid", 64'(s_valid), 64'(0));
    check("small accept pend", 64'(s_pend), 64'(0));
    s_ready = 1'b0;
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
